// File: rtl/pc_predictor_pkg.sv
// Shared defines for the fetch PC predictor: address width, boolean levels,
// the default BTB entry layout and the 2-bit saturating counter encodings.
package pc_predictor_pkg;

    localparam int unsigned ADDR_LEN = 32;
    localparam logic TRUE = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic [ADDR_LEN-1:0] ZERO_ADDR = '0;

    // Default BTB geometry, used for the reference entry layout below
    localparam int unsigned BTB_IDX_W_DEF = 4;
    localparam int unsigned BTB_TAG_W_DEF = ADDR_LEN - BTB_IDX_W_DEF - 2;

    // One BTB entry at the default geometry
    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_W_DEF-1:0] tag;
        logic [ADDR_LEN-1:0]      target;
        logic [1:0]               cnt;
    } btb_entry_t;

    localparam int unsigned BTB_ENTRY_W = $bits(btb_entry_t);

    // Counter encodings: cnt[1] set means predict taken
    localparam logic [1:0] CNT_MIN   = 2'd0;
    localparam logic [1:0] CNT_ALLOC = 2'd2;
    localparam logic [1:0] CNT_MAX   = 2'd3;

    // Tag width for an arbitrary address width and index width
    function automatic int unsigned btb_tag_width(int unsigned addr_len, int unsigned idx_w);
        return addr_len - idx_w - 2;
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup of the fetch PC and
// commit-time training with a 2-bit saturating direction counter per entry.
module pc_btb #(
    parameter int unsigned ADDR_LEN  = 32,
    parameter int unsigned BTB_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] lookup_pc,
    output logic                lookup_taken,
    output logic [ADDR_LEN-1:0] lookup_target,
    input  logic                train_flag,
    input  logic [ADDR_LEN-1:0] train_pc,
    input  logic                train_taken,
    input  logic [ADDR_LEN-1:0] train_target
);
    import pc_predictor_pkg::*;

    localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W = btb_tag_width(ADDR_LEN, IDX_W);

    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
    logic [ADDR_LEN-1:0]  target_q [BTB_DEPTH];
    logic [1:0]           cnt_q    [BTB_DEPTH];

    logic [IDX_W-1:0] l_idx, t_idx;
    logic [TAG_W-1:0] l_tag, t_tag;
    logic             t_hit;
    logic             unused_low_bits;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[ADDR_LEN-1:IDX_W+2];
    assign t_idx = train_pc[IDX_W+1:2];
    assign t_tag = train_pc[ADDR_LEN-1:IDX_W+2];
    // Instructions are word aligned; the byte offset never selects an entry
    assign unused_low_bits = ^{lookup_pc[1:0], train_pc[1:0]};

    // Lookup reads the registered arrays, so a same-cycle training write is not seen
    always_comb begin
        lookup_taken  = FALSE;
        lookup_target = target_q[l_idx];
        if (valid_q[l_idx] && (tag_q[l_idx] == l_tag)) begin
            lookup_taken = cnt_q[l_idx][1];
        end
    end

    assign t_hit = valid_q[t_idx] && (tag_q[t_idx] == t_tag);

    // Training: strengthen/weaken on hit, allocate on a taken miss
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (train_flag) begin
            if (t_hit) begin
                if (train_taken) begin
                    target_q[t_idx] <= train_target;
                    if (cnt_q[t_idx] != CNT_MAX) cnt_q[t_idx] <= cnt_q[t_idx] + 2'd1;
                end else if (cnt_q[t_idx] != CNT_MIN) begin
                    cnt_q[t_idx] <= cnt_q[t_idx] - 2'd1;
                end
            end else if (train_taken) begin
                valid_q[t_idx]  <= TRUE;
                tag_q[t_idx]    <= t_tag;
                target_q[t_idx] <= train_target;
                cnt_q[t_idx]    <= CNT_ALLOC;
            end
        end
    end

endmodule

// File: rtl/pc_predictor.sv
// Fetch PC register with next-PC prediction: redirect from commit beats the
// fetch advance, which follows the BTB prediction or falls through by 4.
module pc_predictor #(
    parameter int unsigned         ADDR_LEN  = pc_predictor_pkg::ADDR_LEN,
    parameter logic [ADDR_LEN-1:0] RESET_PC  = ADDR_LEN'(pc_predictor_pkg::ZERO_ADDR),
    parameter int unsigned         BTB_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                upd_flag_from_if,
    input  logic                commit_flag_from_rob,
    input  logic [ADDR_LEN-1:0] target_pc_from_rob,
    input  logic                train_flag_from_rob,
    input  logic [ADDR_LEN-1:0] train_pc_from_rob,
    input  logic                train_taken_from_rob,
    input  logic [ADDR_LEN-1:0] train_target_from_rob,
    output logic [ADDR_LEN-1:0] pc,
    output logic [ADDR_LEN-1:0] pred_next_pc,
    output logic                pred_taken
);
    import pc_predictor_pkg::*;

    localparam logic [ADDR_LEN-1:0] PC_STEP = ADDR_LEN'(4);

    logic [ADDR_LEN-1:0] pc_q;
    logic [ADDR_LEN-1:0] btb_target;
    logic                btb_taken;

    pc_btb #(
        .ADDR_LEN  (ADDR_LEN),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .lookup_pc     (pc_q),
        .lookup_taken  (btb_taken),
        .lookup_target (btb_target),
        .train_flag    (train_flag_from_rob),
        .train_pc      (train_pc_from_rob),
        .train_taken   (train_taken_from_rob),
        .train_target  (train_target_from_rob)
    );

    // Next-PC prediction: BTB target when predicted taken, else sequential (wraps)
    always_comb begin
        pred_taken   = btb_taken;
        pred_next_pc = btb_taken ? btb_target : (pc_q + PC_STEP);
    end

    // PC register: reset, then redirect, then advance, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (commit_flag_from_rob) begin
            pc_q <= target_pc_from_rob;
        end else if (upd_flag_from_if) begin
            pc_q <= pred_next_pc;
        end
    end

    assign pc = pc_q;

endmodule
